// File: rtl/rcon_stream_gen_if.sv
// Round-constant stream bundle between the Rcon generator and the key-expansion engine.
// The generator drives valid/data/round/last and the consumer drives ready.
interface rcon_stream_gen_if;
  logic       rcon_valid;
  logic       rcon_ready;
  logic [7:0] rcon_data;
  logic [3:0] rcon_round;
  logic       rcon_last;

  modport master (
    output rcon_valid,
    output rcon_data,
    output rcon_round,
    output rcon_last,
    input  rcon_ready
  );

  modport slave (
    input  rcon_valid,
    input  rcon_data,
    input  rcon_round,
    input  rcon_last,
    output rcon_ready
  );
endinterface

// File: rtl/rcon_stream_gen.sv
// Streams AES key-schedule round constants in ascending or descending round order.
// Constants come from xtime / inverse-xtime steps and pass through a GF(2) basis map.
module rcon_stream_gen #(
  parameter int          NUM_ROUNDS = 10,
  parameter logic [7:0]  POLY       = 8'h1B,
  parameter logic [7:0]  RCON_INIT  = 8'h01,
  parameter logic [63:0] MAP_MATRIX = 64'h8040201008040201
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dir,
  input  logic               abort,
  output logic               busy,
  rcon_stream_gen_if.master  bus
);

  typedef enum logic [1:0] {IDLE, PRECOMP, RUN} stateT;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] PRE_LAST   = 4'(NUM_ROUNDS - 2);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
  endfunction

  // Exact inverse of xtime; relies on POLY[0] = 1 to recover the dropped top bit.
  function automatic logic [7:0] invXtime(input logic [7:0] b);
    return b[0] ? (((b ^ POLY) >> 1) | 8'h80) : (b >> 1);
  endfunction

  function automatic logic [7:0] mapBasis(input logic [7:0] rc);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m[i] = ^(MAP_MATRIX[8*i +: 8] & rc);
    end
    return m;
  endfunction

  stateT      r_state;
  logic [7:0] r_rc;
  logic [3:0] r_cnt;
  logic [3:0] r_round;
  logic       r_dir;
  logic       r_valid;
  logic       r_last;
  logic [7:0] r_data;

  logic [7:0] w_xtRc;
  logic [7:0] w_stepRc;
  logic [3:0] w_stepRound;

  assign w_xtRc      = xtime(r_rc);
  assign w_stepRc    = r_dir ? invXtime(r_rc) : w_xtRc;
  assign w_stepRound = r_dir ? (r_round - 4'd1) : (r_round + 4'd1);

  // Descending order first walks rc up to round N-1, then steps back down with inv_xtime.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rc    <= 8'h00;
      r_cnt   <= 4'd0;
      r_round <= 4'd0;
      r_dir   <= 1'b0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= 8'h00;
    end else if (abort) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dir <= dir;
            r_rc  <= RCON_INIT;
            r_cnt <= 4'd0;
            if (!dir) begin
              r_state <= RUN;
              r_valid <= 1'b1;
              r_round <= 4'd0;
              r_data  <= mapBasis(RCON_INIT);
              r_last  <= 1'b0;
            end else begin
              r_state <= PRECOMP;
            end
          end
        end
        PRECOMP: begin
          r_rc  <= w_xtRc;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == PRE_LAST) begin
            r_state <= RUN;
            r_valid <= 1'b1;
            r_round <= LAST_ROUND;
            r_data  <= mapBasis(w_xtRc);
            r_last  <= 1'b0;
          end
        end
        RUN: begin
          if (r_valid && bus.rcon_ready) begin
            if (r_last) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_rc    <= w_stepRc;
              r_round <= w_stepRound;
              r_data  <= mapBasis(w_stepRc);
              r_last  <= r_dir ? (w_stepRound == 4'd0) : (w_stepRound == LAST_ROUND);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = (r_state != IDLE);
  assign bus.rcon_valid = r_valid;
  assign bus.rcon_data  = r_data;
  assign bus.rcon_round = r_round;
  assign bus.rcon_last  = r_last;

endmodule

// File: tb/tb_rcon_stream_gen.sv
// Bench for rcon_stream_gen: three instances (default, 14 rounds, bit-reversed map)
// checked every cycle against a round-index model, plus literal sequence checks.
module tb_rcon_stream_gen;

  localparam logic [63:0] ID_MAP  = 64'h8040201008040201;
  localparam logic [63:0] REV_MAP = 64'h0102040810204080;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic dir = 1'b0;
  logic abort = 1'b0;
  logic ready = 1'b0;
  logic busy0, busy1, busy2;

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;
  int lastStartCycle = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  rcon_stream_gen_if bus0 ();
  rcon_stream_gen_if bus1 ();
  rcon_stream_gen_if bus2 ();

  assign bus0.rcon_ready = ready;
  assign bus1.rcon_ready = ready;
  assign bus2.rcon_ready = ready;

  rcon_stream_gen #(.NUM_ROUNDS(10)) dut0 (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .abort(abort),
    .busy(busy0), .bus(bus0.master)
  );

  rcon_stream_gen #(.NUM_ROUNDS(14)) dut1 (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .abort(abort),
    .busy(busy1), .bus(bus1.master)
  );

  rcon_stream_gen #(.NUM_ROUNDS(10), .MAP_MATRIX(REV_MAP)) dut2 (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .abort(abort),
    .busy(busy2), .bus(bus2.master)
  );

  logic       actValid[3];
  logic       actBusy[3];
  logic       actLast[3];
  logic [7:0] actData[3];
  logic [3:0] actRound[3];

  always_comb begin
    actValid[0] = bus0.rcon_valid; actValid[1] = bus1.rcon_valid; actValid[2] = bus2.rcon_valid;
    actBusy[0]  = busy0;           actBusy[1]  = busy1;           actBusy[2]  = busy2;
    actLast[0]  = bus0.rcon_last;  actLast[1]  = bus1.rcon_last;  actLast[2]  = bus2.rcon_last;
    actData[0]  = bus0.rcon_data;  actData[1]  = bus1.rcon_data;  actData[2]  = bus2.rcon_data;
    actRound[0] = bus0.rcon_round; actRound[1] = bus1.rcon_round; actRound[2] = bus2.rcon_round;
  end

  // Model: round r's constant is x^r in GF(2^8), then the basis map; the sequence is tracked by beat index.
  int          nr[3]  = '{10, 14, 10};
  logic [63:0] mat[3] = '{ID_MAP, ID_MAP, REV_MAP};
  int          mPhase[3] = '{0, 0, 0};
  int          mWait[3]  = '{0, 0, 0};
  int          mBeat[3]  = '{0, 0, 0};
  logic        mDir[3]   = '{1'b0, 1'b0, 1'b0};
  logic        prevValid[3] = '{1'b0, 1'b0, 1'b0};
  int          latSeen[3] = '{0, 0, 0};

  logic [7:0] capQ0[$];
  logic [7:0] capQ1[$];
  logic [7:0] capQ2[$];

  function automatic logic [7:0] mulX(input logic [7:0] a);
    logic [8:0] p;
    p = {a, 1'b0};
    if (p[8]) p = p ^ 9'h11B;
    return p[7:0];
  endfunction

  function automatic logic [7:0] xPow(input int k);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < k; i++) r = mulX(r);
    return r;
  endfunction

  function automatic logic [7:0] basis(input logic [63:0] m, input logic [7:0] v);
    logic [7:0] o;
    o = 8'h00;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) o[i] = o[i] ^ (m[8*i + j] & v[j]);
    end
    return o;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  always @(posedge clk) begin
    cycleCnt++;
    for (int d = 0; d < 3; d++) begin
      if (rst || abort) begin
        mPhase[d] = 0;
      end else begin
        case (mPhase[d])
          0: if (start) begin
               mDir[d] = dir;
               mBeat[d] = 0;
               if (!dir) mPhase[d] = 2;
               else begin
                 mPhase[d] = 1;
                 mWait[d] = nr[d] - 1;
               end
             end
          1: begin
               mWait[d]--;
               if (mWait[d] == 0) mPhase[d] = 2;
             end
          default: if (ready) begin
               if (mBeat[d] == nr[d] - 1) mPhase[d] = 0;
               else mBeat[d]++;
             end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      for (int d = 0; d < 3; d++) begin
        int r;
        checkOutput($sformatf("dut%0d_valid", d), int'(actValid[d]), int'(mPhase[d] == 2));
        checkOutput($sformatf("dut%0d_busy", d), int'(actBusy[d]), int'(mPhase[d] != 0));
        if (mPhase[d] == 2) begin
          r = mDir[d] ? (nr[d] - 1 - mBeat[d]) : mBeat[d];
          checkOutput($sformatf("dut%0d_data", d), int'(actData[d]), int'(basis(mat[d], xPow(r))));
          checkOutput($sformatf("dut%0d_round", d), int'(actRound[d]), r);
          checkOutput($sformatf("dut%0d_last", d), int'(actLast[d]), int'(mBeat[d] == nr[d] - 1));
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      if (actValid[d] && !prevValid[d]) latSeen[d] = cycleCnt - lastStartCycle;
      prevValid[d] = actValid[d];
    end
    if (bus0.rcon_valid && ready) capQ0.push_back(bus0.rcon_data);
    if (bus1.rcon_valid && ready) capQ1.push_back(bus1.rcon_data);
    if (bus2.rcon_valid && ready) capQ2.push_back(bus2.rcon_data);
  end

  task automatic applyStimulus(input logic st, input logic d, input logic ab,
                               input logic rd, input logic rs);
    @(posedge clk);
    #1;
    start = st;
    dir   = d;
    abort = ab;
    ready = rd;
    rst   = rs;
    if (st) lastStartCycle = cycleCnt;
  endtask

  task automatic waitIdle(input int limit, input bit randReady);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      if (mPhase[0] == 0 && mPhase[1] == 0 && mPhase[2] == 0 && !busy0 && !busy1 && !busy2)
        done = 1'b1;
      else
        applyStimulus(1'b0, 1'b0, 1'b0, randReady ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_idle timeout after %0d cycles", limit);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("%s_dut%0d_valid", tag, d), int'(actValid[d]), 0);
      checkOutput($sformatf("%s_dut%0d_data", tag, d), int'(actData[d]), 0);
      checkOutput($sformatf("%s_dut%0d_round", tag, d), int'(actRound[d]), 0);
      checkOutput($sformatf("%s_dut%0d_last", tag, d), int'(actLast[d]), 0);
      checkOutput($sformatf("%s_dut%0d_busy", tag, d), int'(actBusy[d]), 0);
    end
  endtask

  logic [7:0] ascDef[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [7:0] ascRev[10] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'hd8, 8'h6c};
  logic [7:0] tail14[4]  = '{8'h6c, 8'hd8, 8'hab, 8'h4d};

  task automatic clearQueues();
    capQ0.delete();
    capQ1.delete();
    capQ2.delete();
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkResetOutputs("reset");
    checkEn = 1'b1;

    // Ascending order, full-rate consumer.
    clearQueues();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitIdle(60, 1'b0);
    checkOutput("asc_count_dut0", capQ0.size(), 10);
    checkOutput("asc_count_dut1", capQ1.size(), 14);
    checkOutput("asc_count_dut2", capQ2.size(), 10);
    for (int i = 0; i < 10 && i < capQ0.size(); i++)
      checkOutput($sformatf("asc_lit_dut0_%0d", i), int'(capQ0[i]), int'(ascDef[i]));
    for (int i = 0; i < 10 && i < capQ2.size(); i++)
      checkOutput($sformatf("asc_lit_dut2_%0d", i), int'(capQ2[i]), int'(ascRev[i]));
    for (int i = 0; i < 4 && i + 10 < capQ1.size(); i++)
      checkOutput($sformatf("asc_lit_dut1_%0d", i + 10), int'(capQ1[i + 10]), int'(tail14[i]));
    checkOutput("asc_latency_dut0", latSeen[0], 1);
    checkOutput("asc_latency_dut1", latSeen[1], 1);

    // Descending order, full-rate consumer.
    clearQueues();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitIdle(60, 1'b0);
    checkOutput("desc_count_dut0", capQ0.size(), 10);
    for (int i = 0; i < 10 && i < capQ0.size(); i++)
      checkOutput($sformatf("desc_lit_dut0_%0d", i), int'(capQ0[i]), int'(ascDef[9 - i]));
    if (capQ1.size() >= 2) begin
      checkOutput("desc_lit_dut1_0", int'(capQ1[0]), 8'h4d);
      checkOutput("desc_lit_dut1_1", int'(capQ1[1]), 8'hab);
    end else begin
      checkOutput("desc_count_dut1", capQ1.size(), 14);
    end
    checkOutput("desc_latency_dut0", latSeen[0], 10);
    checkOutput("desc_latency_dut1", latSeen[1], 14);
    checkOutput("desc_latency_dut2", latSeen[2], 10);

    // Random backpressure with stray start pulses; the model tracks every accepted beat.
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0,
                    1'($urandom_range(0, 1)), 1'b0);
    waitIdle(500, 1'b1);

    // Abort during PRECOMP, then mid-RUN, then abort colliding with start in IDLE.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("abort_idle_busy0", int'(busy0), 0);
    checkOutput("abort_idle_valid0", int'(bus0.rcon_valid), 0);

    // Reset on beat 5, then a clean restart must give the whole ascending sequence.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkResetOutputs("midrst");
    clearQueues();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitIdle(60, 1'b0);
    checkOutput("restart_count_dut0", capQ0.size(), 10);
    for (int i = 0; i < 10 && i < capQ0.size(); i++)
      checkOutput($sformatf("restart_lit_dut0_%0d", i), int'(capQ0[i]), int'(ascDef[i]));

    @(negedge clk);
    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
